// File: rtl/vit_traceback.sv
// Survivor-memory traceback for the 4-state Viterbi decoder: 3-bank circular store,
// convergence + decode pointers, bits emitted block-reversed with a block-parity toggle.
module vit_traceback #(
    parameter int L           = 21,
    parameter int NS          = 4,
    parameter int START_STATE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NS-1:0] dec_in,
    output logic          decode_out,
    output logic          stack_toggle,
    output logic          out_valid
);

    localparam int            CW   = $clog2(L);
    localparam logic [CW-1:0] LAST = CW'(L - 1);
    localparam logic [1:0]    ST0  = 2'(START_STATE);

    // Predecessor of s_t = {u_t, u_(t-1)} is {u_(t-1), decision}.
    function automatic logic [1:0] pred(input logic [1:0] s, input logic [NS-1:0] d);
        return {s[0], d[s]};
    endfunction

    logic [NS-1:0] mem_q [3][L];
    logic [NS-1:0] mem_d [3][L];

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    wb_q, wb_d;
    logic [1:0]    blk_q, blk_d;
    logic          blk_par_q, blk_par_d;
    logic [1:0]    conv_q, conv_d;
    logic [1:0]    conv_end_q, conv_end_d;
    logic [1:0]    dptr_q, dptr_d;
    logic          decode_out_q, decode_out_d;
    logic          stack_toggle_q, stack_toggle_d;
    logic          out_valid_q, out_valid_d;

    logic          wrap;
    logic [CW-1:0] ridx;
    logic [1:0]    wb_m1, wb_m2;
    logic [1:0]    conv_cur, dptr_cur;

    always_comb begin
        wrap  = (cnt_q == LAST);
        ridx  = LAST - cnt_q;
        wb_m1 = (wb_q == 2'd0) ? 2'd2 : wb_q - 2'd1;
        wb_m2 = (wb_q == 2'd0) ? 2'd1 : (wb_q == 2'd1) ? 2'd2 : 2'd0;

        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        wb_d      = wrap ? ((wb_q == 2'd2) ? 2'd0 : wb_q + 2'd1) : wb_q;
        blk_d     = (wrap && blk_q != 2'd2) ? blk_q + 2'd1 : blk_q;
        blk_par_d = blk_par_q ^ wrap;

        // Convergence: trace the previous bank from a fixed state; its endpoint
        // seeds the next block's decode pass.
        conv_cur   = (cnt_q == '0) ? ST0 : conv_q;
        conv_d     = pred(conv_cur, mem_q[wb_m1][ridx]);
        conv_end_d = wrap ? conv_d : conv_end_q;

        dptr_cur = (cnt_q == '0) ? conv_end_q : dptr_q;
        dptr_d   = pred(dptr_cur, mem_q[wb_m2][ridx]);

        decode_out_d   = dptr_cur[1];
        stack_toggle_d = blk_par_q;
        out_valid_d    = out_valid_q | (blk_q == 2'd2);
    end

    always_comb begin
        mem_d = mem_q;
        mem_d[wb_q][cnt_q] = dec_in;
    end

    // Survivor storage is deliberately left unreset; stale banks are never decoded.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            wb_q           <= '0;
            blk_q          <= '0;
            blk_par_q      <= 1'b0;
            conv_q         <= ST0;
            conv_end_q     <= '0;
            dptr_q         <= ST0;
            decode_out_q   <= 1'b0;
            stack_toggle_q <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            wb_q           <= wb_d;
            blk_q          <= blk_d;
            blk_par_q      <= blk_par_d;
            conv_q         <= conv_d;
            conv_end_q     <= conv_end_d;
            dptr_q         <= dptr_d;
            decode_out_q   <= decode_out_d;
            stack_toggle_q <= stack_toggle_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign decode_out   = decode_out_q;
    assign stack_toggle = stack_toggle_q;
    assign out_valid    = out_valid_q;

endmodule
